// File: rtl/pacman_datapath.sv
// Pac-Man game datapath: positions, heading, move-rate timer, score, ghost LFSR
// and a registered one-cell plot request toward the VGA adapter.
module pacman_datapath #(
    parameter int unsigned GRID_W    = 16,
    parameter int unsigned GRID_H    = 12,
    parameter int unsigned START_X   = 1,
    parameter int unsigned START_Y   = 1,
    parameter int unsigned TIMER_MAX = 25000000,
    parameter int unsigned WALL_Y    = 6,
    parameter int unsigned WALL_X0   = 4,
    parameter int unsigned WALL_X1   = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] direction,
    input  logic       en_x_position,
    input  logic [1:0] s_x_position,
    input  logic       en_y_position,
    input  logic [1:0] s_y_position,
    input  logic       en_direction,
    input  logic [1:0] s_direction,
    input  logic       en_timer,
    input  logic [1:0] s_timer,
    input  logic       en_score,
    input  logic       s_score,
    input  logic       s_game_over,
    input  logic       en_ghostRand,
    input  logic       move_index,
    input  logic [1:0] s_plot_color,
    input  logic [1:0] s_screen,
    input  logic       plot,
    output logic       timer_done,
    output logic       touchingGhost,
    output logic       touchingWall,
    output logic [7:0] score,
    output logic       game_over,
    output logic [1:0] screen,
    output logic [3:0] plot_x,
    output logic [3:0] plot_y,
    output logic [2:0] plot_colour,
    output logic       plot_en
);
    localparam int unsigned TMR_W = 25;

    localparam logic [3:0]       X_MAX     = 4'(GRID_W - 1);
    localparam logic [3:0]       Y_MAX     = 4'(GRID_H - 1);
    localparam logic [3:0]       X_START   = 4'(START_X);
    localparam logic [3:0]       Y_START   = 4'(START_Y);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMER_MAX - 1);
    localparam logic [4:0]       WY        = 5'(WALL_Y);
    localparam logic [4:0]       WX0       = 5'(WALL_X0);
    localparam logic [4:0]       WX1       = 5'(WALL_X1);
    localparam logic [7:0]       LFSR_SEED = 8'hA5;

    logic [3:0]       px;
    logic [3:0]       py;
    logic [1:0]       dir;
    logic [TMR_W-1:0] tmr;
    logic [7:0]       lfsr;
    logic             lfsr_fb;
    logic [3:0]       gx;
    logic [3:0]       gy;
    logic [2:0]       colour_d;
    logic [4:0]       px_w, py_w, px_p1, px_m1, py_p1, py_m1;
    logic             px_in_wall, px_p1_in_wall, px_m1_in_wall;

    // Ghost cell folded into the grid; raw nibbles are below 2*GRID so one subtract suffices
    always_comb begin
        lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        gx = lfsr[3:0];
        if ({1'b0, lfsr[3:0]} >= 5'(GRID_W)) gx = lfsr[3:0] - 4'(GRID_W);
        gy = lfsr[7:4];
        if ({1'b0, lfsr[7:4]} >= 5'(GRID_H)) gy = lfsr[7:4] - 4'(GRID_H);
    end

    assign touchingGhost = (px == gx) && (py == gy);

    // Next-cell blocking check; 5-bit arithmetic keeps px-1 at 0 out of the wall range
    always_comb begin
        px_w          = {1'b0, px};
        py_w          = {1'b0, py};
        px_p1         = px_w + 5'd1;
        px_m1         = px_w - 5'd1;
        py_p1         = py_w + 5'd1;
        py_m1         = py_w - 5'd1;
        px_in_wall    = (px_w >= WX0) && (px_w <= WX1);
        px_p1_in_wall = (px_p1 >= WX0) && (px_p1 <= WX1);
        px_m1_in_wall = (px_m1 >= WX0) && (px_m1 <= WX1);
        case (dir)
            2'b00:   touchingWall = (px == X_MAX) || ((py_w == WY) && px_p1_in_wall);
            2'b01:   touchingWall = (px == 4'd0)  || ((py_w == WY) && px_m1_in_wall);
            2'b10:   touchingWall = (py == 4'd0)  || ((py_m1 == WY) && px_in_wall);
            default: touchingWall = (py == Y_MAX) || ((py_p1 == WY) && px_in_wall);
        endcase
    end

    always_comb begin
        case (s_plot_color)
            2'b00:   colour_d = 3'b000;
            2'b01:   colour_d = 3'b110;
            2'b10:   colour_d = 3'b100;
            default: colour_d = 3'b001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            px          <= X_START;
            py          <= Y_START;
            dir         <= 2'b00;
            tmr         <= '0;
            timer_done  <= 1'b0;
            score       <= 8'd0;
            game_over   <= 1'b0;
            screen      <= 2'b00;
            lfsr        <= LFSR_SEED;
            plot_x      <= 4'd0;
            plot_y      <= 4'd0;
            plot_colour <= 3'b000;
            plot_en     <= 1'b0;
        end else begin
            if (en_x_position) begin
                case (s_x_position)
                    2'b00:   px <= X_START;
                    2'b01:   if (px < X_MAX) px <= px + 4'd1;
                    2'b10:   if (px != 4'd0) px <= px - 4'd1;
                    default: ;
                endcase
            end
            if (en_y_position) begin
                case (s_y_position)
                    2'b00:   py <= Y_START;
                    2'b01:   if (py < Y_MAX) py <= py + 4'd1;
                    2'b10:   if (py != 4'd0) py <= py - 4'd1;
                    default: ;
                endcase
            end
            if (en_direction) begin
                case (s_direction)
                    2'b00:   dir <= direction;
                    2'b01:   dir <= 2'b00;
                    default: ;
                endcase
            end

            // timer_done is a single-cycle pulse, low unless the wrap happens this edge
            timer_done <= 1'b0;
            if (en_timer) begin
                case (s_timer)
                    2'b00: tmr <= '0;
                    2'b01: begin
                        if (tmr >= TMR_LAST) begin
                            tmr        <= '0;
                            timer_done <= 1'b1;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end

            if (en_score) begin
                if (!s_score)             score <= 8'd0;
                else if (score != 8'hFF)  score <= score + 8'd1;
            end
            if (s_game_over) game_over <= 1'b1;
            screen <= (s_screen == 2'b11) ? 2'b01 : s_screen;
            if (en_ghostRand) lfsr <= {lfsr[6:0], lfsr_fb};

            plot_en <= plot;
            if (plot) begin
                plot_x      <= move_index ? gx : px;
                plot_y      <= move_index ? gy : py;
                plot_colour <= colour_d;
            end
        end
    end

endmodule

// File: tb/tb_pacman_datapath.sv
// Randomized scoreboard bench for pacman_datapath against a cell-level game model.
module tb_pacman_datapath;
    localparam int W = 16, H = 12, SX = 1, SY = 1, TMAX = 4, WY = 6, WX0 = 4, WX1 = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] direction = '0;
    logic       en_x_position = 1'b0, en_y_position = 1'b0, en_direction = 1'b0;
    logic [1:0] s_x_position = '0, s_y_position = '0, s_direction = '0, s_timer = '0;
    logic       en_timer = 1'b0, en_score = 1'b0, s_score = 1'b0, s_game_over = 1'b0;
    logic       en_ghostRand = 1'b0, move_index = 1'b0, plot = 1'b0;
    logic [1:0] s_plot_color = '0, s_screen = '0;
    logic       timer_done, touchingGhost, touchingWall, game_over, plot_en;
    logic [7:0] score;
    logic [1:0] screen;
    logic [3:0] plot_x, plot_y;
    logic [2:0] plot_colour;

    pacman_datapath #(.GRID_W(W), .GRID_H(H), .START_X(SX), .START_Y(SY), .TIMER_MAX(TMAX),
                      .WALL_Y(WY), .WALL_X0(WX0), .WALL_X1(WX1)) dut (
        .clk(clk), .reset(reset), .direction(direction),
        .en_x_position(en_x_position), .s_x_position(s_x_position),
        .en_y_position(en_y_position), .s_y_position(s_y_position),
        .en_direction(en_direction), .s_direction(s_direction),
        .en_timer(en_timer), .s_timer(s_timer), .en_score(en_score), .s_score(s_score),
        .s_game_over(s_game_over), .en_ghostRand(en_ghostRand), .move_index(move_index),
        .s_plot_color(s_plot_color), .s_screen(s_screen), .plot(plot),
        .timer_done(timer_done), .touchingGhost(touchingGhost), .touchingWall(touchingWall),
        .score(score), .game_over(game_over), .screen(screen), .plot_x(plot_x),
        .plot_y(plot_y), .plot_colour(plot_colour), .plot_en(plot_en));

    always #5 clk = ~clk;

    typedef struct {
        int rst, dirn, enx, sx, eny, sy, endr, sd, ent, st, ens, ss, sgo, eng, mi, pc, sscr, plt;
    } in_t;
    typedef struct { int done, tg, tw, score, go, scr, px, py, pc, pe; } exp_t;
    typedef struct { int x, y, c; } plot_t;

    exp_t  exp_q[$];
    plot_t plot_q[$];
    int    checks = 0;
    int    failures = 0;

    // Reference game state
    int m_px, m_py, m_dir, m_tmr, m_done, m_score, m_go, m_scr, m_lfsr;
    int m_plx, m_ply, m_plc, m_ple;

    task automatic check(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int ghost_x(); return (m_lfsr % 16) % W; endfunction
    function automatic int ghost_y(); return (m_lfsr / 16) % H; endfunction

    function automatic int blocked();
        int nx = m_px, ny = m_py;
        case (m_dir)
            0: nx = nx + 1;
            1: nx = nx - 1;
            2: ny = ny - 1;
            default: ny = ny + 1;
        endcase
        if (nx < 0 || nx >= W || ny < 0 || ny >= H) return 1;
        return (ny == WY && nx >= WX0 && nx <= WX1) ? 1 : 0;
    endfunction

    function automatic int colour_of(input int pc);
        case (pc)
            0: return 0;
            1: return 6;
            2: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int move(input int v, input int sel, input int start, input int lim);
        case (sel)
            0: return start;
            1: return (v + 1 > lim) ? lim : v + 1;
            2: return (v == 0) ? 0 : v - 1;
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_px = SX; m_py = SY; m_dir = 0; m_tmr = 0; m_done = 0; m_score = 0; m_go = 0;
        m_scr = 0; m_lfsr = 'hA5; m_plx = 0; m_ply = 0; m_plc = 0; m_ple = 0;
    endtask

    task automatic model_step(input in_t i);
        int fb;
        if (i.rst != 0) begin
            model_reset();
            return;
        end
        m_ple = i.plt;
        if (i.plt != 0) begin
            m_plx = (i.mi != 0) ? ghost_x() : m_px;
            m_ply = (i.mi != 0) ? ghost_y() : m_py;
            m_plc = colour_of(i.pc);
            plot_q.push_back('{m_plx, m_ply, m_plc});
        end
        if (i.enx != 0) m_px = move(m_px, i.sx, SX, W - 1);
        if (i.eny != 0) m_py = move(m_py, i.sy, SY, H - 1);
        if (i.endr != 0 && i.sd == 0) m_dir = i.dirn;
        if (i.endr != 0 && i.sd == 1) m_dir = 0;
        m_done = 0;
        if (i.ent != 0 && i.st == 0) m_tmr = 0;
        if (i.ent != 0 && i.st == 1) begin
            m_tmr = (m_tmr + 1) % TMAX;
            if (m_tmr == 0) m_done = 1;
        end
        if (i.ens != 0) m_score = (i.ss == 0) ? 0 : ((m_score >= 255) ? 255 : m_score + 1);
        if (i.sgo != 0) m_go = 1;
        m_scr = (i.sscr == 3) ? 1 : i.sscr;
        if (i.eng != 0) begin
            fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
            m_lfsr = ((m_lfsr * 2) + fb) % 256;
        end
    endtask

    function automatic in_t idle();
        in_t i = '{default: 0};
        return i;
    endfunction

    // Apply one cycle of inputs at the falling edge and queue the model's post-edge view
    task automatic drive(input in_t i);
        @(negedge clk);
        reset = i.rst != 0;            direction = 2'(i.dirn);
        en_x_position = i.enx != 0;    s_x_position = 2'(i.sx);
        en_y_position = i.eny != 0;    s_y_position = 2'(i.sy);
        en_direction = i.endr != 0;    s_direction = 2'(i.sd);
        en_timer = i.ent != 0;         s_timer = 2'(i.st);
        en_score = i.ens != 0;         s_score = i.ss != 0;
        s_game_over = i.sgo != 0;      en_ghostRand = i.eng != 0;
        move_index = i.mi != 0;        s_plot_color = 2'(i.pc);
        s_screen = 2'(i.sscr);         plot = i.plt != 0;
        model_step(i);
        exp_q.push_back('{m_done, ((m_px == ghost_x()) && (m_py == ghost_y())) ? 1 : 0,
                          blocked(), m_score, m_go, m_scr, m_plx, m_ply, m_plc, m_ple});
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every post-edge state against the scoreboard, every plot strobe against the plot queue
    initial begin
        exp_t  e;
        plot_t p;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("timer_done", int'(timer_done), e.done);
                check("touchingGhost", int'(touchingGhost), e.tg);
                check("touchingWall", int'(touchingWall), e.tw);
                check("score", int'(score), e.score);
                check("game_over", int'(game_over), e.go);
                check("screen", int'(screen), e.scr);
                check("plot_x", int'(plot_x), e.px);
                check("plot_y", int'(plot_y), e.py);
                check("plot_colour", int'(plot_colour), e.pc);
                check("plot_en", int'(plot_en), e.pe);
            end
            if (plot_en) begin
                if (plot_q.size() == 0) begin
                    check("plot_unexpected", 1, 0);
                end else begin
                    p = plot_q.pop_front();
                    check("plot_txn_x", int'(plot_x), p.x);
                    check("plot_txn_y", int'(plot_y), p.y);
                    check("plot_txn_colour", int'(plot_colour), p.c);
                end
            end
        end
    end

    initial begin
        in_t i;
        model_reset();
        i = idle(); i.rst = 1;
        drive(i); drive(i);
        i = idle(); drive(i); settle();
        check("rst_score", int'(score), 0);
        check("rst_status", int'({timer_done, touchingGhost, touchingWall, game_over}), 0);
        check("rst_screen", int'(screen), 0);

        i = idle(); i.plt = 1; i.mi = 1; i.pc = 2; drive(i); settle();
        check("rst_ghost_x", int'(plot_x), 5);
        check("rst_ghost_y", int'(plot_y), 10);
        check("ghost_colour_red", int'(plot_colour), 4);
        check("plot_en_set", int'(plot_en), 1);
        i = idle(); i.plt = 1; i.pc = 1; drive(i); settle();
        check("rst_pac_xy", int'({plot_x, plot_y}), 8'h11);
        check("pac_colour_yellow", int'(plot_colour), 6);

        // Timer with a clear at cycle 6
        for (int c = 1; c <= 14; c++) begin
            i = idle(); i.ent = 1; i.st = (c == 6) ? 0 : 1; drive(i); settle();
            check($sformatf("timer_c%0d", c), int'(timer_done), (c == 4 || c == 10 || c == 14) ? 1 : 0);
        end

        // Left edge: heading load and step on the same edge, then a blocked step
        i = idle(); i.endr = 1; i.sd = 0; i.dirn = 1; i.enx = 1; i.sx = 2; drive(i); settle();
        check("wall_left_edge", int'(touchingWall), 1);
        i = idle(); i.enx = 1; i.sx = 2; drive(i);
        i = idle(); i.plt = 1; drive(i); settle();
        check("px_sat_zero", int'(plot_x), 0);

        // Down into the inner wall from (5,5)
        i = idle(); i.enx = 1; i.sx = 0; i.eny = 1; i.sy = 0; drive(i);
        for (int k = 0; k < 4; k++) begin
            i = idle(); i.enx = 1; i.sx = 1; i.eny = 1; i.sy = 1; drive(i);
        end
        i = idle(); i.endr = 1; i.sd = 0; i.dirn = 3; drive(i); settle();
        check("wall_inner_down", int'(touchingWall), 1);

        // Ghost step to (10,4) and Pac-Man onto it
        i = idle(); i.eng = 1; drive(i);
        for (int k = 0; k < 5; k++) begin
            i = idle(); i.enx = 1; i.sx = 1; drive(i);
        end
        i = idle(); i.eny = 1; i.sy = 2; drive(i); settle();
        check("touching_ghost", int'(touchingGhost), 1);
        i = idle(); i.plt = 1; i.mi = 1; i.pc = 3; drive(i); settle();
        check("ghost_step_xy", int'({plot_x, plot_y}), 8'hA4);
        check("ghost_colour_blue", int'(plot_colour), 1);

        // Score saturation and clear
        for (int k = 0; k < 260; k++) begin
            i = idle(); i.ens = 1; i.ss = 1; drive(i);
        end
        settle();
        check("score_sat", int'(score), 255);
        i = idle(); i.ens = 1; drive(i); settle();
        check("score_clear", int'(score), 0);

        // Sticky game over, reserved screen code, and reset clearing both
        i = idle(); i.sgo = 1; drive(i);
        i = idle(); i.sscr = 3; drive(i); drive(i); settle();
        check("game_over_sticky", int'(game_over), 1);
        check("screen_reserved", int'(screen), 1);
        i = idle(); i.rst = 1; i.plt = 1; i.ent = 1; i.st = 1; i.sgo = 1; drive(i); settle();
        check("game_over_reset", int'(game_over), 0);
        check("plot_en_reset", int'(plot_en), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            i.rst  = ($urandom_range(99) == 0) ? 1 : 0;
            i.dirn = int'($urandom_range(3));
            i.enx  = int'($urandom_range(1));  i.sx = int'($urandom_range(3));
            i.eny  = int'($urandom_range(1));  i.sy = int'($urandom_range(3));
            i.endr = int'($urandom_range(1));  i.sd = int'($urandom_range(3));
            i.ent  = ($urandom_range(3) != 0) ? 1 : 0;
            i.st   = ($urandom_range(7) == 0) ? int'($urandom_range(3)) : 1;
            i.ens  = int'($urandom_range(1));  i.ss = ($urandom_range(15) != 0) ? 1 : 0;
            i.sgo  = ($urandom_range(199) == 0) ? 1 : 0;
            i.eng  = int'($urandom_range(1));
            i.mi   = int'($urandom_range(1));  i.pc = int'($urandom_range(3));
            i.sscr = int'($urandom_range(3));  i.plt = int'($urandom_range(1));
            drive(i);
        end
        i = idle(); drive(i);
        settle(); settle();
        check("scoreboard_drained", exp_q.size() + plot_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pacman_datapath.md
# pacman_datapath

Datapath half of the Pac-Man game engine; the counterpart that consumes every select/enable the `controller` FSM drives and returns its status inputs (`timer_done`, `touchingGhost`, `touchingWall`). It holds Pac-Man and ghost cell positions, the heading register, the move-rate timer, the score and the game-over flag. It also registers a one-cell plot request toward the VGA adapter. All state is on a single clock with synchronous active-high reset.

## Interface
- `GRID_W`, 16: playfield width in cells (8..16).
- `GRID_H`, 12: playfield height in cells (8..16).
- `START_X`, 1: Pac-Man reset/load column.
- `START_Y`, 1: Pac-Man reset/load row.
- `TIMER_MAX`, 25000000: move-rate period in clocks (≥2).
- `WALL_Y`, 6: row of the inner wall.
- `WALL_X0`, 4: first column of the inner wall.
- `WALL_X1`, 11: last column of the inner wall.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high; reset is synchronous and active-high, one clock domain.
- `direction` in 2: joystick heading. 00 right, 01 left, 10 up, 11 down.
- `en_x_position`, `s_x_position` in 1/2: Pac-Man column control.
- `en_y_position`, `s_y_position` in 1/2: Pac-Man row control.
- `en_direction`, `s_direction` in 1/2: heading register control.
- `en_timer`, `s_timer` in 1/2: timer control.
- `en_score`, `s_score` in 1/1: score control.
- `s_game_over` in 1: set the game-over flag.
- `en_ghostRand` in 1: advance the ghost LFSR.
- `move_index` in 1: plot source. 0 = Pac-Man cell, 1 = ghost cell.
- `s_plot_color` in 2: plot colour. 00 black, 01 yellow, 10 red, 11 blue.
- `s_screen` in 2: screen mode. 00 title, 01 play, 10 game over, 11 reserved (treated as 01).
- `plot` in 1: request one cell write.
- `timer_done` out 1: one-cycle pulse at timer wrap.
- `touchingGhost` out 1: Pac-Man cell equals ghost cell.
- `touchingWall` out 1: next step along the current heading is blocked.
- `score` out 8: current score.
- `game_over` out 1: sticky game-over flag.
- `screen` out 2: registered screen mode.
- `plot_x`, `plot_y` out 4/4: cell coordinates to the VGA adapter.
- `plot_colour` out 3: RGB colour. 000 black, 110 yellow, 100 red, 001 blue.
- `plot_en` out 1: write strobe to the VGA adapter.

## Operation
- **Position registers (`px`, `py`, 4 bits each).** Update only when the corresponding enable is 1.
  - Select 00 loads START.
  - Select 01 increments, saturating at GRID-1.
  - Select 10 decrements, saturating at 0.
  - Select 11 holds.
- **Heading register (`dir`).** Updates only when `en_direction`=1.
  - `s_direction` 00 loads `direction`.
  - 01 loads 00 (right).
  - 1x holds.
- **Timer (`tmr`, 25 bits).** Updates only when `en_timer`=1.
  - `s_timer` 00 clears to 0.
  - 01 counts up. At TIMER_MAX-1 it wraps to 0 and `timer_done` is registered high for exactly that next cycle.
  - 1x holds.
  - `timer_done` is 0 in every other cycle, including when the timer is disabled or cleared.
- **Score.** Updates only when `en_score`=1.
  - `s_score`=0 clears to 0.
  - `s_score`=1 increments, saturating at 255.
- **Game-over flag.** Set when `s_game_over`=1; cleared only by reset.
- **Screen.** `screen` <= `s_screen` every cycle; 11 is stored as 01.
- **Ghost LFSR (8 bits).**
  - Seed 0xA5.
  - Fibonacci form, taps 8,6,5,4: `new_bit` = l[7]^l[5]^l[4]^l[3]; shift left, with `new_bit` entering at l[0].
  - Shifts when `en_ghostRand`=1.
  - The ghost cell is derived from the post-shift value on the same edge: `gx` = l[3:0] mod GRID_W; `gy` = l[7:4], minus GRID_H if l[7:4] ≥ GRID_H.
- **`touchingGhost`.** Combinational: (`px`==`gx`) && (`py`==`gy`).
- **`touchingWall`.** Combinational from `px`, `py`, `dir`. It is 1 if the next cell is off-grid or lies on the inner wall (row WALL_Y, columns WALL_X0..WALL_X1).
  - Right: `px`==GRID_W-1, or (`py`==WALL_Y && `px`+1 in [WALL_X0, WALL_X1]).
  - Left: `px`==0, or (`py`==WALL_Y && `px`-1 in [WALL_X0, WALL_X1]).
  - Up: `py`==0, or (`py`-1==WALL_Y && `px` in [WALL_X0, WALL_X1]).
  - Down: `py`==GRID_H-1, or (`py`+1==WALL_Y && `px` in [WALL_X0, WALL_X1]).
- **Plot path.** On `plot`=1, register `plot_x`/`plot_y` from the source selected by `move_index`, register `plot_colour` from the decoded `s_plot_color`, and assert `plot_en`. `plot_en` equals `plot` delayed by one cycle.

## Timing
- **Reset values.**
  - `px`=START_X, `py`=START_Y, `dir`=00, `tmr`=0.
  - `timer_done`=0, `score`=0, `game_over`=0, `screen`=00.
  - LFSR=0xA5, giving `gx`=5 and `gy`=10 (GRID 16×12).
  - `plot_x`=0, `plot_y`=0, `plot_colour`=000, `plot_en`=0.
- Reset has priority over every enable, including reset asserted mid-count or mid-plot.
- **Latency.**
  - Register effects are visible one cycle after the enable.
  - `touchingGhost`/`touchingWall` settle in the same cycle the registers change (zero added latency).
  - `plot` → `plot_en`: one cycle.
- **Simultaneous events.**
  - X and Y updates on the same edge are independent.
  - A heading load and a position step on the same edge: the step uses the old `dir` only via the controller's selects; the datapath never self-steps.
- Controller handshake: the FSM samples `timer_done` as a single-cycle pulse and must not hold `en_timer` low across a wrap expecting a later pulse.

## Test plan
- **Reset.** Reset for 2 cycles → `px`=1, `py`=1, `gx`=5, `gy`=10, `score`=0, all status outputs 0.
- **Timer.** TIMER_MAX=4, `en_timer`=1, `s_timer`=01 → `timer_done` high on cycles 4, 8, 12 after release; clearing with `s_timer`=00 at cycle 6 moves the next pulse to cycle 10.
- **Walls.**
  - `dir`=01 at `px`=0 → `touchingWall`=1; stepping with `s_x_position`=10 keeps `px`=0.
  - `px`=5, `py`=5, `dir`=11 (down) → `touchingWall`=1.
- **Ghost.**
  - One `en_ghostRand` pulse → LFSR 0x4A, ghost (10,4).
  - Moving Pac-Man to (10,4) → `touchingGhost`=1.
- **Score.** 260 increments → `score` saturates at 255; then `s_score`=0 → 0.
- **Plot and game over.**
  - `plot`=1, `move_index`=1, `s_plot_color`=10 → next cycle `plot_en`=1, (`plot_x`,`plot_y`)=ghost cell, `plot_colour`=100.
  - `s_game_over` pulse → `game_over` stays 1 until reset.
